// File: rtl/fsm_ring_sequencer.sv
// Parametrised ring sequencer: up/down/ping-pong/hold with per-state dwell.
// Tracks visited states, emits a wrap pulse and a sticky illegal-state flag.
module fsm_ring_sequencer #(
    parameter int NUM_STATES = 4,
    parameter int STATE_W    = 2,
    parameter int DWELL_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [1:0]            mode,
    input  logic [DWELL_W-1:0]    dwell,
    input  logic                  load,
    input  logic [STATE_W-1:0]    load_state,
    output logic [STATE_W-1:0]    state,
    output logic                  out,
    output logic                  dir,
    output logic                  wrap,
    output logic [NUM_STATES-1:0] visited,
    output logic                  all_visited,
    output logic                  illegal
);

    typedef enum logic [1:0] {
        MODE_UP   = 2'b00,
        MODE_DOWN = 2'b01,
        MODE_PING = 2'b10,
        MODE_HOLD = 2'b11
    } mode_e;

    localparam logic [STATE_W:0]   N_EXT  = (STATE_W+1)'(NUM_STATES);
    localparam logic [STATE_W-1:0] LAST   = STATE_W'(NUM_STATES - 1);
    localparam logic [STATE_W-1:0] PENULT = STATE_W'(NUM_STATES - 2);
    localparam logic [STATE_W-1:0] ZERO   = '0;
    localparam logic [STATE_W-1:0] ONE    = STATE_W'(1);

    mode_e                  mode_q;
    logic [DWELL_W-1:0]     dwell_cnt;
    logic [DWELL_W-1:0]     cnt_d;
    logic [STATE_W-1:0]     state_d;
    logic                   dir_d;
    logic                   wrap_d;
    logic [NUM_STATES-1:0]  vis_d;
    logic                   ill_d;
    logic                   upd;
    logic                   state_ok;
    logic                   load_ok;

    assign mode_q      = mode_e'(mode);
    assign state_ok    = {1'b0, state} < N_EXT;
    assign load_ok     = {1'b0, load_state} < N_EXT;
    assign out         = (state == LAST);
    assign all_visited = &visited;

    // Register all sequencer state; reset returns to state 0 with bit0 visited.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= '0;
            dwell_cnt <= '0;
            dir       <= 1'b0;
            wrap      <= 1'b0;
            visited   <= NUM_STATES'(1);
            illegal   <= 1'b0;
        end else begin
            state     <= state_d;
            dwell_cnt <= cnt_d;
            dir       <= dir_d;
            wrap      <= wrap_d;
            visited   <= vis_d;
            illegal   <= ill_d;
        end
    end

    // Next-state: load beats enable; dwell gates each advance.
    always_comb begin
        state_d = state;
        cnt_d   = dwell_cnt;
        dir_d   = dir;
        wrap_d  = 1'b0;
        vis_d   = visited;
        ill_d   = illegal | ~state_ok;
        upd     = 1'b0;
        if (load) begin
            if (load_ok) begin
                state_d = load_state;
                cnt_d   = '0;
                upd     = 1'b1;
            end else begin
                ill_d = 1'b1;
            end
        end else if (en && mode_q != MODE_HOLD) begin
            if (dwell_cnt < dwell) begin
                cnt_d = dwell_cnt + 1'b1;
            end else begin
                cnt_d = '0;
                upd   = 1'b1;
                unique case (mode_q)
                    MODE_UP: begin
                        if (state == LAST) begin
                            state_d = ZERO;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state + ONE;
                        end
                    end
                    MODE_DOWN: begin
                        if (state == ZERO) begin
                            state_d = LAST;
                            wrap_d  = 1'b1;
                        end else begin
                            state_d = state - ONE;
                        end
                    end
                    MODE_PING: begin
                        if (!dir) begin
                            if (state == LAST) begin
                                state_d = PENULT;
                                dir_d   = 1'b1;
                            end else begin
                                state_d = state + ONE;
                            end
                        end else begin
                            if (state == ZERO) begin
                                state_d = ONE;
                                dir_d   = 1'b0;
                                wrap_d  = 1'b1;
                            end else begin
                                state_d = state - ONE;
                            end
                        end
                    end
                    default: begin
                        state_d = state;
                    end
                endcase
            end
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            if (upd && state_d == STATE_W'(i)) begin
                vis_d[i] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fsm_ring_sequencer.sv
// Scoreboard bench for fsm_ring_sequencer (4-state and 3-state instances).
// Reference model predicts each cycle; results are queued and compared.
module tb_fsm_ring_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       load;
    logic [1:0] mode;
    logic [1:0] ls;
    logic [3:0] dwell;

    logic [1:0] state;
    logic       out;
    logic       dir;
    logic       wrap;
    logic [3:0] visited;
    logic       all_visited;
    logic       illegal;

    logic       bload;
    logic [1:0] bls;
    logic [1:0] bstate;
    logic       bout;
    logic       bdir;
    logic       bwrap;
    logic [2:0] bvis;
    logic       ball;
    logic       bill;

    always #5 clk = ~clk;

    fsm_ring_sequencer #(.NUM_STATES(4), .STATE_W(2), .DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .dwell(dwell),
        .load(load), .load_state(ls), .state(state), .out(out),
        .dir(dir), .wrap(wrap), .visited(visited),
        .all_visited(all_visited), .illegal(illegal)
    );

    fsm_ring_sequencer #(.NUM_STATES(3), .STATE_W(2), .DWELL_W(4)) dut3 (
        .clk(clk), .rst(rst), .en(1'b0), .mode(2'b00), .dwell(4'd0),
        .load(bload), .load_state(bls), .state(bstate), .out(bout),
        .dir(bdir), .wrap(bwrap), .visited(bvis),
        .all_visited(ball), .illegal(bill)
    );

    typedef struct {
        int s;
        int d;
        int w;
        int v;
        int il;
    } exp_t;

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;
    int m_s, m_c, m_dir, m_wrap, m_vis, m_ill;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_s = 0; m_c = 0; m_dir = 0; m_wrap = 0; m_vis = 1; m_ill = 0;
    endtask

    task automatic model_step(input int e, input int md, input int dw,
                              input int ld, input int lsv);
        m_wrap = 0;
        if (ld != 0) begin
            if (lsv < 4) begin
                m_s = lsv;
                m_c = 0;
                m_vis = m_vis | (1 << lsv);
            end else begin
                m_ill = 1;
            end
        end else if (e != 0 && md != 3) begin
            if (m_c < dw) begin
                m_c = m_c + 1;
            end else begin
                m_c = 0;
                if (md == 0) begin
                    m_s = (m_s + 1) % 4;
                    m_wrap = (m_s == 0);
                end else if (md == 1) begin
                    m_wrap = (m_s == 0);
                    m_s = (m_s + 3) % 4;
                end else if (m_dir == 0) begin
                    if (m_s == 3) begin m_s = 2; m_dir = 1; end
                    else m_s = m_s + 1;
                end else begin
                    if (m_s == 0) begin m_s = 1; m_dir = 0; m_wrap = 1; end
                    else m_s = m_s - 1;
                end
                m_vis = m_vis | (1 << m_s);
            end
        end
    endtask

    task automatic step(input int e, input int md, input int dw,
                        input int ld, input int lsv);
        exp_t x;
        en = e[0]; mode = md[1:0]; dwell = dw[3:0];
        load = ld[0]; ls = lsv[1:0];
        model_step(e, md, dw, ld, lsv);
        sb.push_back('{m_s, m_dir, m_wrap, m_vis, m_ill});
        @(posedge clk);
        #1;
        x = sb.pop_front();
        check("state", 32'(state), x.s);
        check("out", 32'(out), 32'(x.s == 3));
        check("dir", 32'(dir), x.d);
        check("wrap", 32'(wrap), x.w);
        check("visited", 32'(visited), x.v);
        check("all_visited", 32'(all_visited), 32'(x.v == 15));
        check("illegal", 32'(illegal), x.il);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; load = 1'b0; mode = 2'b00;
        ls = 2'd0; dwell = 4'd0; bload = 1'b0; bls = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_visited", 32'(visited), 1);
        check("rst_out", 32'(out), 0);
        check("rst_all", 32'(all_visited), 0);
        check("rst_wrap", 32'(wrap), 0);
        check("rst_illegal", 32'(illegal), 0);
        check("rst_b_vis", 32'(bvis), 1);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) step(1, 0, 2, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 2, 0, 0);
        for (int i = 0; i < 6; i++) step(1, 0, 2, 0, 0);

        step(0, 0, 0, 1, 0);
        for (int i = 0; i < 8; i++) step(1, 2, 0, 0, 0);

        step(1, 1, 0, 1, 2);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);

        step(1, 0, 2, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 3, 2, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 0, 2, 0, 0);

        for (int i = 0; i < 300; i++) begin
            step(int'($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)));
        end

        step(0, 0, 3, 1, 2);
        step(1, 0, 3, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check("arst_state", 32'(state), 0);
        check("arst_visited", 32'(visited), 1);
        check("arst_wrap", 32'(wrap), 0);
        check("arst_illegal", 32'(illegal), 0);
        check("arst_dir", 32'(dir), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        step(1, 0, 0, 0, 0);

        en = 1'b0; load = 1'b0;
        bload = 1'b1; bls = 2'd2;
        @(posedge clk);
        #1;
        check("b_load_state", 32'(bstate), 2);
        check("b_load_vis", 32'(bvis), 5);
        check("b_load_out", 32'(bout), 1);
        check("b_ill0", 32'(bill), 0);
        bls = 2'd3;
        @(posedge clk);
        #1;
        check("b_bad_state", 32'(bstate), 2);
        check("b_bad_ill", 32'(bill), 1);
        check("b_bad_vis", 32'(bvis), 5);
        bload = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("b_ill_sticky", 32'(bill), 1);
        check("b_wrap", 32'(bwrap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fsm_ring_sequencer.md
Name:
fsm_ring_sequencer

Overview:
- Parametrised successor to the fixed 2-bit FSM: a NUM_STATES-state sequencer with up, down, ping-pong and hold modes.
- Adds a per-state dwell counter, synchronous state load, a wrap pulse, a sticky visited bitmap and an illegal-state flag.
- Sits under the formal harness flow, with a companion harness. Each visited bit and all_visited are cover targets; illegal is an assert-never target.

Parameters:
- NUM_STATES, 4, number of legal states (0..NUM_STATES-1); must be >= 2.
- STATE_W, 2, state register width; must satisfy 2**STATE_W >= NUM_STATES.
- DWELL_W, 4, width of the dwell count and dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  advance enable; counts or steps only when high.
- mode  input  2  00 up, 01 down, 10 ping-pong, 11 hold.
- dwell  input  DWELL_W  extra enabled cycles to stay in each state.
- load  input  1  synchronous state load request.
- load_state  input  STATE_W  target state for load.
- state  output  STATE_W  current state register.
- out  output  1  high when state == NUM_STATES-1 (combinational decode of the state register, no latency).
- dir  output  1  ping-pong direction (0 up, 1 down).
- wrap  output  1  one-cycle registered wrap pulse.
- visited  output  NUM_STATES  sticky bitmap of states entered since reset.
- all_visited  output  1  AND-reduction of visited.
- illegal  output  1  sticky error flag.

Behaviour:
- Reset (asynchronous, any time, including mid-dwell or mid-load):
  - state=0, dwell_cnt=0, dir=0, wrap=0, illegal=0.
  - visited=1 (only bit0 set), all_visited=0, out=0.
- Priority each cycle: load > en > idle. With en low and load low, all registers hold and wrap=0.
- Load:
  - If load_state < NUM_STATES: state<=load_state, dwell_cnt<=0, visited[load_state]<=1; dir and wrap are unaffected (wrap=0).
  - Otherwise: state unchanged, dwell_cnt unchanged, illegal<=1.
  - Load ignores en and mode.
- Enabled step (en=1, load=0):
  - mode=11: full hold; dwell_cnt is not incremented.
  - Other modes: if dwell_cnt < dwell, then dwell_cnt++ and state holds. Otherwise dwell_cnt<=0 and the state advances.
  - Result: a state persists for dwell+1 enabled cycles. dwell=0 advances on every enabled cycle.
  - The comparison is live, so lowering dwell mid-dwell forces an advance on the next enabled cycle.
- Advance rules:
  - Up: N-1 -> 0 with wrap; otherwise +1.
  - Down: 0 -> N-1 with wrap; otherwise -1.
  - Ping-pong, dir=0: at N-1, go to N-2 and set dir<=1; otherwise +1.
  - Ping-pong, dir=1: at 0, go to 1, set dir<=0 and wrap; otherwise -1.
  - Up and down modes leave dir unchanged.
- wrap is registered: it is high in the same cycle that state first shows the wrapped value, for exactly one cycle.
- Every advance sets visited[new state].
- Mode change mid-dwell: dwell_cnt is kept; the new mode's rule applies at the next advance. Switching from ping-pong to up/down keeps the dir value.
- illegal is also set whenever the state register holds a value >= NUM_STATES. This is unreachable by design and serves as the formal assert target. illegal clears only on rst.
- Formal properties:
  - state < NUM_STATES always.
  - wrap never high for two consecutive cycles.
  - visited is monotonic between resets.

Test Plan:
- Reset, then mode=00, dwell=0, en=1 for 5 cycles -> state 0,1,2,3,0; wrap high only in the cycle state=0 reappears; out high while state=3; all_visited=1 after cycle 3.
- mode=00, dwell=2, en=1 -> each state held exactly 3 enabled cycles; dropping en for 2 cycles mid-dwell extends that state by 2 cycles.
- mode=10, dwell=0, 8 enabled cycles from 0 -> 1,2,3,2,1,0,1,2; dir=1 from the 3->2 step; wrap on the 0->1 step only.
- load=1 with load_state=2 while en=1, mode=01 -> state=2 next cycle, dwell_cnt=0, visited[2]=1. With NUM_STATES=3 and load_state=3 -> state unchanged and illegal=1 sticky.
- Assert rst asynchronously mid-dwell (dwell_cnt=1, state=2) -> state=0, visited=1, wrap=0, illegal=0 immediately, without waiting for a clock edge.
- mode=11 with en=1 for 4 cycles -> state and dwell_cnt frozen; switch to mode=00 -> advance resumes from the preserved dwell_cnt.
